// File: rtl/uart_rx_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_pkt_ctrl
// Brief    : Frames UART receiver bytes (SOF, LEN, payload[, checksum]) into
//            a held packet with valid/ack handshake and a registered read port.
//            The checksum byte exists only when UART_PKT_CHECKSUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_pkt_ctrl #(
  parameter logic [7:0] SOF     = 8'hA5,
  parameter int         MAX_LEN = 16,
  parameter int         ADDR_W  = 4,
  parameter int         TIMEOUT = 20000
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_rx_ready,
  input  logic [7:0]        i_rx_data,
  output logic              o_rx_clear,
  output logic              o_pkt_valid,
  output logic [ADDR_W:0]   o_pkt_len,
  input  logic              i_pkt_ack,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [7:0]        o_rd_data,
  output logic              o_len_err,
  output logic              o_csum_err,
  output logic              o_timeout,
  output logic              o_overrun
);

  localparam int              CNT_W       = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W:0]  C_IDX_ONE  = (ADDR_W + 1)'(1);
  localparam logic [7:0]       C_MAX_LEN  = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_PAY  = 3'd2,
`ifdef UART_PKT_CHECKSUM_EN
    S_CSUM = 3'd3,
`endif
    S_HOLD = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               r_rx_clear;
  logic               w_accept;
  logic [ADDR_W:0]    r_len;
  logic [ADDR_W:0]    r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_cnt_expired;
  logic               w_in_frame;
  logic               w_last_pay;
  logic               w_len_ok;
  logic               w_buf_we;
  logic               w_len_err;
  logic               w_timeout;
  logic               w_overrun;
  logic               r_len_err;
  logic               r_timeout;
  logic               r_overrun;
  logic [7:0]         r_rd_data;
  logic [7:0]         r_buf [0:(1<<ADDR_W)-1];

  // The receiver needs a cycle to drop its ready flag after a clear pulse.
  assign w_accept      = i_rx_ready && !r_rx_clear;
  assign w_cnt_expired = (r_cnt == C_CNT_LAST);
  assign w_last_pay    = (r_idx == (r_len - C_IDX_ONE));
  assign w_len_ok      = (i_rx_data <= C_MAX_LEN);

`ifdef UART_PKT_CHECKSUM_EN
  logic [7:0] r_sum;
  logic [7:0] w_sum_next;
  logic       w_csum_err;
  logic       r_csum_err;

  assign w_sum_next = r_sum + i_rx_data;
  assign w_in_frame = (r_state == S_LEN) || (r_state == S_PAY) || (r_state == S_CSUM);
`else
  assign w_in_frame = (r_state == S_LEN) || (r_state == S_PAY);
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_len_err    = 1'b0;
    w_timeout    = 1'b0;
    w_overrun    = 1'b0;
    w_buf_we     = 1'b0;
`ifdef UART_PKT_CHECKSUM_EN
    w_csum_err   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_accept && (i_rx_data == SOF)) w_next_state = S_LEN;
      end
      S_LEN: begin
        if (w_accept) begin
          if (!w_len_ok) begin
            w_len_err    = 1'b1;
            w_next_state = S_IDLE;
          end else if (i_rx_data == 8'd0) begin
`ifdef UART_PKT_CHECKSUM_EN
            w_next_state = S_CSUM;
`else
            w_next_state = S_HOLD;
`endif
          end else begin
            w_next_state = S_PAY;
          end
        end
      end
      S_PAY: begin
        if (w_accept) begin
          w_buf_we = i_reset_n;
          if (w_last_pay) begin
`ifdef UART_PKT_CHECKSUM_EN
            w_next_state = S_CSUM;
`else
            w_next_state = S_HOLD;
`endif
          end
        end
      end
`ifdef UART_PKT_CHECKSUM_EN
      S_CSUM: begin
        if (w_accept) begin
          if (w_sum_next == 8'd0) begin
            w_next_state = S_HOLD;
          end else begin
            w_csum_err   = 1'b1;
            w_next_state = S_IDLE;
          end
        end
      end
`endif
      S_HOLD: begin
        // Bytes arriving while the host still owns the buffer are dropped.
        if (w_accept)  w_overrun    = 1'b1;
        if (i_pkt_ack) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
    if (w_in_frame && !w_accept && w_cnt_expired) begin
      w_timeout    = 1'b1;
      w_next_state = S_IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_rx_clear <= 1'b0;
      r_len      <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_len_err  <= 1'b0;
      r_timeout  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_rx_clear <= w_accept;
      r_len_err  <= w_len_err;
      r_timeout  <= w_timeout;
      r_overrun  <= w_overrun;
      if ((r_state == S_LEN) && w_accept && w_len_ok) begin
        r_len <= i_rx_data[ADDR_W:0];
        r_idx <= '0;
      end else if (w_buf_we) begin
        r_idx <= r_idx + C_IDX_ONE;
      end
      if (w_in_frame && !w_accept && !w_cnt_expired) begin
        r_cnt <= r_cnt + C_CNT_ONE;
      end else begin
        r_cnt <= '0;
      end
    end
  end

`ifdef UART_PKT_CHECKSUM_EN
  // The running sum starts from the length byte, so a good frame totals zero.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_sum      <= 8'd0;
      r_csum_err <= 1'b0;
    end else begin
      r_csum_err <= w_csum_err;
      if ((r_state == S_LEN) && w_accept) begin
        r_sum <= i_rx_data;
      end else if (w_buf_we) begin
        r_sum <= w_sum_next;
      end
    end
  end

  assign o_csum_err = r_csum_err;
`else
  assign o_csum_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (w_buf_we) r_buf[r_idx[ADDR_W-1:0]] <= i_rx_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_rd_data <= 8'd0;
    end else begin
      r_rd_data <= r_buf[i_rd_addr];
    end
  end

  assign o_rx_clear  = r_rx_clear;
  assign o_pkt_valid = (r_state == S_HOLD);
  assign o_pkt_len   = r_len;
  assign o_rd_data   = r_rd_data;
  assign o_len_err   = r_len_err;
  assign o_timeout   = r_timeout;
  assign o_overrun   = r_overrun;

endmodule
`default_nettype wire
